// File: rtl/vme_bus_arbiter2.sv
// vme_bus_arbiter2: round-robin arbiter sharing one register-bank slave port between two masters,
// one transaction at a time, with a completion timeout so a silent slave cannot hang a master.
module vme_bus_arbiter2 #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_rd,
    input  logic        m0_wr,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic [17:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_rd,
    input  logic        m1_wr,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [17:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_rd,
    output logic        s_wr,
    input  logic [31:0] s_rdata,
    input  logic        s_rd_done,
    input  logic        s_wr_done,
    input  logic        s_rd_err,
    input  logic        s_wr_err,
    output logic        late_ack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    state_t     state, state_nx;
    logic       owner, is_wr, last_grant, res_err;
    logic [7:0] cnt;
    logic       req0, req1, grant, ack, ack_err, tmo, finish, stray;
    always_comb begin
        req0    = m0_rd | m0_wr;
        req1    = m1_rd | m1_wr;
        grant   = (req0 & req1) ? ~last_grant : req1;
        ack     = is_wr ? s_wr_done : s_rd_done;
        ack_err = is_wr ? s_wr_err : s_rd_err;
        tmo     = cnt == CNT_LAST;
        finish  = (state == WAIT) & (ack | tmo);
        // in WAIT only the other ack type is stray; elsewhere every ack is
        stray   = (state == WAIT) ? (is_wr ? s_rd_done : s_wr_done) : (s_rd_done | s_wr_done);
    end
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req0 | req1) ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (ack | tmo) ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        s_rd    = (state == ISSUE) & ~is_wr;
        s_wr    = (state == ISSUE) & is_wr;
        m0_done = (state == DONE) & ~owner;
        m1_done = (state == DONE) & owner;
        m0_err  = m0_done & res_err;
        m1_err  = m1_done & res_err;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            is_wr      <= 1'b0;
            last_grant <= 1'b1;
            res_err    <= 1'b0;
            cnt        <= 8'd0;
            s_addr     <= 18'd0;
            s_wdata    <= 32'd0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
            late_ack   <= 1'b0;
        end else begin
            if (state == IDLE && (req0 | req1)) begin
                owner   <= grant;
                is_wr   <= grant ? m1_wr : m0_wr;
                s_addr  <= grant ? m1_addr : m0_addr;
                s_wdata <= grant ? m1_wdata : m0_wdata;
            end
            cnt <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
            // an ack in the final WAIT cycle beats the timeout
            if (finish) begin
                res_err <= ~ack | ack_err;
                if (!is_wr && !owner)
                    m0_rdata <= ack ? s_rdata : ERR_DATA;
                if (!is_wr && owner)
                    m1_rdata <= ack ? s_rdata : ERR_DATA;
            end
            if (state == DONE)
                last_grant <= owner;
            late_ack <= stray;
        end
    end
endmodule

// File: tb/tb_vme_bus_arbiter2.sv
// tb_vme_bus_arbiter2: scenario tasks plus randomized rounds against a transaction-level model
// of the arbiter, using a latency-programmable slave responder.
module tb_vme_bus_arbiter2;
    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hFFFFFFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [17:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [17:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_rd, s_wr;
    logic [31:0] s_rdata = '0;
    logic        s_rd_done = 1'b0, s_wr_done = 1'b0, s_rd_err = 1'b0, s_wr_err = 1'b0;
    logic        late_ack;

    int tests = 0, fails = 0, cyc = 0;

    typedef struct {int m; int c; logic err; logic [31:0] rdata;} ev_t;
    typedef struct {logic wr; int c; logic [17:0] addr; logic [31:0] wdata;} st_t;
    ev_t         done_q[$];
    st_t         strb_q[$];
    int          late_q[$];
    int          lat_q[$];
    bit          err_q[$];
    logic [31:0] dat_q[$];

    vme_bus_arbiter2 #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd), .s_wr(s_wr),
        .s_rdata(s_rdata), .s_rd_done(s_rd_done), .s_wr_done(s_wr_done),
        .s_rd_err(s_rd_err), .s_wr_err(s_wr_err), .late_ack(late_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m0_done) done_q.push_back('{0, cyc, m0_err, m0_rdata});
        if (m1_done) done_q.push_back('{1, cyc, m1_err, m1_rdata});
        if (s_rd || s_wr) strb_q.push_back('{s_wr, cyc, s_addr, s_wdata});
        if (late_ack) late_q.push_back(cyc);
        if (s_rd || s_wr || m0_done || m1_done) begin
            tests++;
            if ((s_rd && s_wr) || (m0_done && m1_done)) begin
                fails++;
                $display("FAIL exclusive: s_rd=%0b s_wr=%0b m0_done=%0b m1_done=%0b at cycle %0d, required at most one of each pair",
                         s_rd, s_wr, m0_done, m1_done, cyc);
            end
        end
    end

    // slave: acks L cycles after the strobe (L=0 means never), per queued settings
    initial begin : slave
        bit w, e;
        int l;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (s_rd || s_wr) begin
                w = s_wr; l = 1; e = 1'b0; d = $urandom;
                if (lat_q.size() > 0) l = lat_q.pop_front();
                if (err_q.size() > 0) e = err_q.pop_front();
                if (dat_q.size() > 0) d = dat_q.pop_front();
                if (l > 0) begin
                    repeat (l) @(posedge clk);
                    #1;
                    if (w) begin s_wr_done = 1'b1; s_wr_err = e; end
                    else begin s_rd_done = 1'b1; s_rd_err = e; s_rdata = d; end
                    @(posedge clk);
                    #1;
                    s_rd_done = 1'b0; s_wr_done = 1'b0; s_rd_err = 1'b0; s_wr_err = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_q();
        done_q.delete(); strb_q.delete(); late_q.delete();
        lat_q.delete(); err_q.delete(); dat_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic start(output int c0);
        @(posedge clk); #1;
        c0 = cyc;
    endtask

    task automatic wait_and_drop(input int n, output bit to);
        int got = 0;
        for (int k = 0; k < 60 && got < n; k++) begin
            bit d0, d1;
            @(negedge clk);
            d0 = m0_done; d1 = m1_done;
            if (d0 || d1) begin
                got += int'(d0) + int'(d1);
                @(posedge clk); #1;
                if (d0) begin m0_rd = 1'b0; m0_wr = 1'b0; end
                if (d1) begin m1_rd = 1'b0; m1_wr = 1'b0; end
            end
        end
        to = got < n;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({m0_rdata, m1_rdata, m0_done, m0_err, m1_done, m1_err, s_addr, s_wdata, s_rd, s_wr, late_ack} !== '0) begin
            fails++;
            $display("FAIL reset_values: m0_rdata=%h m1_rdata=%h done/err=%b%b%b%b s_addr=%h s_wdata=%h s_rd=%b s_wr=%b late_ack=%b, required all zero",
                     m0_rdata, m1_rdata, m0_done, m0_err, m1_done, m1_err, s_addr, s_wdata, s_rd, s_wr, late_ack);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({s_rd, s_wr, m0_done, m1_done, late_ack} !== 5'b0 || strb_q.size() != 0) begin
            fails++;
            $display("FAIL idle_quiet: s_rd=%b s_wr=%b m0_done=%b m1_done=%b late_ack=%b strobes=%0d, required all 0 with no request",
                     s_rd, s_wr, m0_done, m1_done, late_ack, strb_q.size());
        end
    endtask

    task automatic test_basic_read();
        int c0;
        bit to;
        clear_q();
        lat_q.push_back(1); err_q.push_back(1'b0); dat_q.push_back(32'h0000BEEF);
        start(c0);
        m0_addr = 18'h00001; m0_rd = 1'b1;
        wait_and_drop(1, to);
        repeat (2) @(negedge clk);
        tests++;
        if (to) begin fails++; $display("FAIL basic_read_wait: no m0_done within budget, required one"); end
        tests++;
        if (strb_q.size() != 1 || strb_q[0].wr !== 1'b0 || strb_q[0].c - c0 != 1 || strb_q[0].addr !== 18'h00001) begin
            fails++;
            $display("FAIL basic_read_strobe: got %0d strobes wr=%b rel_cycle=%0d addr=%h, required 1 read at cycle 1 addr 00001",
                     strb_q.size(), strb_q[0].wr, strb_q[0].c - c0, strb_q[0].addr);
        end
        tests++;
        if (done_q.size() != 1 || done_q[0].m != 0 || done_q[0].c - c0 != 3 || done_q[0].err !== 1'b0 || done_q[0].rdata !== 32'h0000BEEF) begin
            fails++;
            $display("FAIL basic_read_done: got %0d dones m=%0d rel_cycle=%0d err=%b rdata=%h, required m0 at cycle 3 err 0 rdata 0000beef",
                     done_q.size(), done_q[0].m, done_q[0].c - c0, done_q[0].err, done_q[0].rdata);
        end
        tests++;
        if (m0_rdata !== 32'h0000BEEF) begin
            fails++;
            $display("FAIL basic_read_hold: m0_rdata=%h after completion, required 0000beef", m0_rdata);
        end
    endtask

    task automatic test_arbitration();
        int c0;
        bit to;
        do_reset();
        start(c0);
        m0_addr = 18'h00010; m0_wdata = 32'hA5A50001; m0_wr = 1'b1;
        m1_addr = 18'h00020; m1_rd = 1'b1;
        wait_and_drop(2, to);
        repeat (2) @(negedge clk);
        tests++;
        if (to || done_q.size() != 2 || done_q[0].m != 0 || done_q[1].m != 1) begin
            fails++;
            $display("FAIL first_tie_order: timeout=%b dones=%0d order=%0d,%0d, required m0 then m1",
                     to, done_q.size(), done_q[0].m, done_q[1].m);
        end
        tests++;
        if (strb_q.size() != 2 || strb_q[0].wr !== 1'b1 || strb_q[0].addr !== 18'h00010 || strb_q[0].wdata !== 32'hA5A50001 ||
            strb_q[1].wr !== 1'b0 || strb_q[1].addr !== 18'h00020) begin
            fails++;
            $display("FAIL first_tie_strobes: got %0d strobes wr=%b,%b addr=%h,%h wdata0=%h, required wr to 00010 (a5a50001) then rd 00020",
                     strb_q.size(), strb_q[0].wr, strb_q[1].wr, strb_q[0].addr, strb_q[1].addr, strb_q[0].wdata);
        end
        start(c0);
        m0_addr = 18'h00030; m0_rd = 1'b1;
        wait_and_drop(1, to);
        clear_q();
        start(c0);
        m0_addr = 18'h00040; m0_rd = 1'b1;
        m1_addr = 18'h00050; m1_wdata = 32'h00C0FFEE; m1_wr = 1'b1;
        wait_and_drop(2, to);
        repeat (2) @(negedge clk);
        tests++;
        if (to || done_q.size() != 2 || done_q[0].m != 1 || done_q[1].m != 0 || strb_q[0].wr !== 1'b1 || strb_q[0].addr !== 18'h00050) begin
            fails++;
            $display("FAIL second_tie_order: timeout=%b dones=%0d order=%0d,%0d first_addr=%h, required m1 (wr 00050) then m0",
                     to, done_q.size(), done_q[0].m, done_q[1].m, strb_q[0].addr);
        end
    endtask

    task automatic test_timeout();
        int c0;
        bit to;
        clear_q();
        lat_q.push_back(7); err_q.push_back(1'b0); dat_q.push_back(32'h11111111);
        start(c0);
        m1_addr = 18'h3FFFF; m1_rd = 1'b1;
        wait_and_drop(1, to);
        repeat (4) @(negedge clk);
        tests++;
        if (to || done_q.size() != 1 || done_q[0].m != 1 || done_q[0].c - c0 != 6 || done_q[0].err !== 1'b1 || done_q[0].rdata !== ERRD) begin
            fails++;
            $display("FAIL timeout_done: timeout=%b dones=%0d m=%0d rel_cycle=%0d err=%b rdata=%h, required one m1 done at cycle 6 err 1 rdata ffffffff",
                     to, done_q.size(), done_q[0].m, done_q[0].c - c0, done_q[0].err, done_q[0].rdata);
        end
        tests++;
        if (late_q.size() != 1 || late_q[0] - c0 != 9) begin
            fails++;
            $display("FAIL timeout_late_ack: got %0d pulses first at rel_cycle %0d, required 1 pulse at cycle 9", late_q.size(), late_q[0] - c0);
        end
    endtask

    task automatic test_write_err();
        int c0;
        bit to;
        clear_q();
        lat_q.push_back(2); err_q.push_back(1'b1); dat_q.push_back(32'h22222222);
        start(c0);
        m1_addr = 18'h00ABC; m1_wdata = 32'h13579BDF; m1_wr = 1'b1;
        wait_and_drop(1, to);
        repeat (2) @(negedge clk);
        tests++;
        if (strb_q.size() != 1 || strb_q[0].wr !== 1'b1 || strb_q[0].wdata !== 32'h13579BDF || strb_q[0].addr !== 18'h00ABC) begin
            fails++;
            $display("FAIL write_err_strobe: got %0d strobes wr=%b addr=%h wdata=%h, required one write to 00abc of 13579bdf",
                     strb_q.size(), strb_q[0].wr, strb_q[0].addr, strb_q[0].wdata);
        end
        tests++;
        if (to || done_q.size() != 1 || done_q[0].m != 1 || done_q[0].c - c0 != 4 || done_q[0].err !== 1'b1 || m1_rdata !== ERRD) begin
            fails++;
            $display("FAIL write_err_done: timeout=%b dones=%0d m=%0d rel_cycle=%0d err=%b m1_rdata=%h, required m1 at cycle 4 err 1 rdata ffffffff",
                     to, done_q.size(), done_q[0].m, done_q[0].c - c0, done_q[0].err, m1_rdata);
        end
    endtask

    task automatic test_rdwr_both();
        int c0;
        bit to;
        clear_q();
        lat_q.push_back(1); err_q.push_back(1'b0); dat_q.push_back(32'h12345678);
        start(c0);
        m0_addr = 18'h00100; m0_rd = 1'b1;
        wait_and_drop(1, to);
        clear_q();
        lat_q.push_back(1); err_q.push_back(1'b0); dat_q.push_back(32'h99999999);
        start(c0);
        m0_addr = 18'h00200; m0_wdata = 32'hDEAD0042; m0_rd = 1'b1; m0_wr = 1'b1;
        wait_and_drop(1, to);
        repeat (2) @(negedge clk);
        tests++;
        if (strb_q.size() != 1 || strb_q[0].wr !== 1'b1 || strb_q[0].wdata !== 32'hDEAD0042) begin
            fails++;
            $display("FAIL rdwr_strobe: got %0d strobes wr=%b wdata=%h, required a single write strobe with dead0042",
                     strb_q.size(), strb_q[0].wr, strb_q[0].wdata);
        end
        tests++;
        if (to || done_q.size() != 1 || done_q[0].c - c0 != 3 || done_q[0].err !== 1'b0 || m0_rdata !== 32'h12345678) begin
            fails++;
            $display("FAIL rdwr_done: timeout=%b dones=%0d rel_cycle=%0d err=%b m0_rdata=%h, required done at cycle 3 err 0 rdata 12345678",
                     to, done_q.size(), done_q[0].c - c0, done_q[0].err, m0_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        bit to;
        clear_q();
        lat_q.push_back(5); err_q.push_back(1'b0); dat_q.push_back(32'h33333333);
        start(c0);
        m0_addr = 18'h00777; m0_wdata = 32'h44444444; m0_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; m0_rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({m0_rdata, m1_rdata, m0_done, m0_err, m1_done, m1_err, s_addr, s_wdata, s_rd, s_wr, late_ack} !== '0) begin
            fails++;
            $display("FAIL midreset_values: m0_rdata=%h m1_rdata=%h done/err=%b%b%b%b s_addr=%h s_wdata=%h s_rd=%b s_wr=%b, required all zero",
                     m0_rdata, m1_rdata, m0_done, m0_err, m1_done, m1_err, s_addr, s_wdata, s_rd, s_wr);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_q.size() != 0 || late_q.size() != 1 || late_q[0] - c0 != 7) begin
            fails++;
            $display("FAIL midreset_stray: dones=%0d late_pulses=%0d first at rel_cycle %0d, required 0 dones and 1 late_ack at cycle 7",
                     done_q.size(), late_q.size(), late_q[0] - c0);
        end
        clear_q();
        lat_q.push_back(2); err_q.push_back(1'b0); dat_q.push_back(32'h0BADF00D);
        start(c0);
        m0_addr = 18'h00042; m0_rd = 1'b1;
        wait_and_drop(1, to);
        repeat (2) @(negedge clk);
        tests++;
        if (to || done_q.size() != 1 || done_q[0].m != 0 || done_q[0].c - c0 != 4 || done_q[0].err !== 1'b0 || done_q[0].rdata !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL midreset_recover: timeout=%b dones=%0d m=%0d rel_cycle=%0d err=%b rdata=%h, required m0 at cycle 4 err 0 rdata 0badf00d",
                     to, done_q.size(), done_q[0].m, done_q[0].c - c0, done_q[0].err, done_q[0].rdata);
        end
    endtask

    // model: a tie goes to the master not served last; latency min(L,TMO)+1 from strobe to done
    task automatic test_random();
        int last;
        logic [31:0] exp_rd [2];
        do_reset();
        last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        for (int r = 0; r < 30; r++) begin
            int pick, n, c0;
            bit to, lok;
            int ord [2];
            bit rd [2], wr [2], e [2];
            logic [17:0] a [2];
            logic [31:0] w [2], d [2];
            int lat [2];
            int late_exp[$];
            pick = $urandom_range(0, 2);
            for (int m = 0; m < 2; m++) begin
                wr[m]  = 1'($urandom_range(0, 1));
                rd[m]  = wr[m] ? 1'($urandom_range(0, 1)) : 1'b1;
                a[m]   = 18'($urandom);
                w[m]   = $urandom;
                d[m]   = $urandom;
                lat[m] = $urandom_range(1, TMO + 1);
                e[m]   = 1'($urandom_range(0, 1));
            end
            n = (pick == 2) ? 2 : 1;
            ord[0] = (pick == 2) ? ((last == 1) ? 0 : 1) : pick;
            ord[1] = 1 - ord[0];
            clear_q();
            for (int i = 0; i < n; i++) begin
                lat_q.push_back(lat[ord[i]]); err_q.push_back(e[ord[i]]); dat_q.push_back(d[ord[i]]);
            end
            start(c0);
            for (int i = 0; i < n; i++) begin
                if (ord[i] == 0) begin m0_addr = a[0]; m0_wdata = w[0]; m0_rd = rd[0]; m0_wr = wr[0]; end
                else begin m1_addr = a[1]; m1_wdata = w[1]; m1_rd = rd[1]; m1_wr = wr[1]; end
            end
            wait_and_drop(n, to);
            repeat (3) @(negedge clk);
            tests++;
            if (to || done_q.size() != n || strb_q.size() != n) begin
                fails++;
                $display("FAIL rand_count r%0d: timeout=%b dones=%0d strobes=%0d, required %0d of each", r, to, done_q.size(), strb_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    int m, eff;
                    logic exp_err;
                    m = ord[i];
                    eff = (lat[m] > TMO) ? TMO : lat[m];
                    exp_err = (lat[m] > TMO) ? 1'b1 : e[m];
                    if (!wr[m]) exp_rd[m] = (lat[m] > TMO) ? ERRD : d[m];
                    tests++;
                    if (strb_q[i].wr !== wr[m] || strb_q[i].addr !== a[m] || (wr[m] && strb_q[i].wdata !== w[m])) begin
                        fails++;
                        $display("FAIL rand_strobe r%0d.%0d: wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                                 r, i, strb_q[i].wr, strb_q[i].addr, strb_q[i].wdata, wr[m], a[m], w[m]);
                    end
                    tests++;
                    if (done_q[i].m != m || done_q[i].c - strb_q[i].c != eff + 1 || done_q[i].err !== exp_err || done_q[i].rdata !== exp_rd[m]) begin
                        fails++;
                        $display("FAIL rand_done r%0d.%0d: m=%0d lat=%0d err=%b rdata=%h, required m=%0d lat=%0d err=%b rdata=%h",
                                 r, i, done_q[i].m, done_q[i].c - strb_q[i].c, done_q[i].err, done_q[i].rdata, m, eff + 1, exp_err, exp_rd[m]);
                    end
                    if (lat[m] > TMO) late_exp.push_back(strb_q[i].c + lat[m] + 1);
                end
            end
            lok = late_q.size() == late_exp.size();
            for (int i = 0; i < late_exp.size() && lok; i++) lok = late_q[i] == late_exp[i];
            tests++;
            if (!lok) begin
                fails++;
                $display("FAIL rand_late r%0d: got %0d late_ack pulses, required %0d at the expected cycles", r, late_q.size(), late_exp.size());
            end
            last = ord[n - 1];
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_arbitration();
        test_timeout();
        test_write_err();
        test_rdwr_both();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vme_bus_arbiter2.md
# vme_bus_arbiter2

Two-master arbiter that shares one register-bank slave port (18-bit word address, 32-bit data, single-cycle Rd/Wr strobes with a Done/Error handshake) between two independent requesters, e.g. a VME host interface and a local sequencer. Requests are granted round-robin, one transaction at a time, with a programmable completion timeout. The block sits between the masters and the existing generated register modules, and a slave that never acknowledges cannot hang either master.

## Interface
- TIMEOUT, default 255: cycles to wait for slave Done after the strobe before aborting; legal range 2..255.
- ERR_DATA, default 32'hFFFFFFFF: read data returned to a master on timeout.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- m0_addr / m1_addr  in  18  word address [19:2]; held stable while the request is high.
- m0_wdata / m1_wdata  in  32  write data; held stable while wr is high.
- m0_rd / m1_rd  in  1  read request level; held until the matching done.
- m0_wr / m1_wr  in  1  write request level; held until the matching done.
- m0_rdata / m1_rdata  out  32  registered read data; valid with done, held until that master's next completion.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  qualifies done: slave error or timeout.
- s_addr  out  18  slave word address.
- s_wdata  out  32  slave write data.
- s_rd  out  1  one-cycle slave read strobe.
- s_wr  out  1  one-cycle slave write strobe.
- s_rdata  in  32  slave read data, sampled when s_rd_done=1.
- s_rd_done, s_wr_done  in  1  slave acknowledges.
- s_rd_err, s_wr_err  in  1  slave error; valid with the matching done.
- late_ack  out  1  one-cycle pulse when a slave done arrives while no transaction is waiting for it.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state: IDLE.
- A master requests when rd or wr is high. If a master drives both, the transaction is a write.
- IDLE: if any request is high, grant it and latch owner, type, addr and wdata into the s_* registers, then go to ISSUE.
- Arbitration: a single requester wins. If both request in the same cycle, the master not granted last wins. last_grant resets to 1, so m0 wins the first tie.
- ISSUE (exactly 1 cycle): s_rd or s_wr = 1 per the latched type. Clear the timeout counter. Go to WAIT.
- WAIT: s_rd and s_wr = 0. s_addr and s_wdata are held stable from ISSUE to the end of WAIT. The counter increments each cycle.
  - The matching done (s_rd_done for reads, s_wr_done for writes) captures s_rdata (reads only) and the matching err, then goes to DONE.
  - If the counter reaches TIMEOUT with no done, set err=1, return ERR_DATA on reads, then go to DONE.
  - If done and timeout fall in the same cycle, done wins.
  - The non-matching done type is ignored and pulses late_ack.
- DONE (exactly 1 cycle): owner's mN_done=1 and mN_err is driven. For reads, mN_rdata is updated in the same cycle. Update last_grant. Go to IDLE.
- Writes leave mN_rdata unchanged.
- A slave done outside WAIT is ignored and pulses late_ack the following cycle. This covers acks arriving after a timeout.
- Reset mid-transaction: return to IDLE and issue no done pulse. Any subsequent stray ack is reported as late_ack.

## Timing
- Reset values: all m*_rdata = 0, m*_done = 0, m*_err = 0, s_addr = 0, s_wdata = 0, s_rd = 0, s_wr = 0, late_ack = 0.
- Cycle numbering: request first high in cycle 0 with FSM in IDLE. Strobe is in cycle 1. If the slave asserts done in cycle 1+L (L≥1), mN_done is high in cycle 2+L.
- Example: a slave with L=1 read latency gives done in cycle 3. With L=2 write latency, done is in cycle 4.
- Timeout: with no ack, done+err is in cycle 2+TIMEOUT.
- Masters deassert the request in the cycle after done. The FSM is in IDLE that cycle and samples the request at its end, so the same request is never granted twice.
- Back-to-back throughput is at most one transaction per 4 cycles (IDLE, ISSUE, WAIT≥1, DONE).
- At most one s_rd/s_wr pulse per transaction. s_rd and s_wr are never high together.

## Test plan
- m0 read at addr 0x00001, slave returns 32'h0000BEEF with done 1 cycle after the strobe -> one s_rd pulse in cycle 1, m0_done in cycle 3, m0_rdata=32'h0000BEEF, m0_err=0.
- m0 write and m1 read both requested in cycle 0 after reset -> m0 served first (s_wr), then m1 (s_rd). A repeated simultaneous pair alternates grants m1, m0.
- Slave never acks, TIMEOUT=4, m1 read -> m1_done and m1_err=1 in cycle 6, m1_rdata=32'hFFFFFFFF. A slave ack injected 2 cycles later -> late_ack pulse, no mN_done.
- Slave asserts s_wr_err with s_wr_done on an m1 write -> m1_done=1, m1_err=1, m1_rdata unchanged.
- rst_n low for 1 cycle during WAIT -> all outputs at reset values next cycle, no done pulse. A subsequent m0 read completes normally.
- m0 drives rd and wr together -> s_wr pulse only, s_rd stays 0, s_wdata = m0_wdata.
